// File: rtl/clb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clb_pkg
// Description : Shared types and bitstream field widths for the CLB cluster.
// Revision    : 1.0 - initial release
// ============================================================================
package clb_pkg;

    localparam int BS_TYPE_W = 2;
    localparam int BS_IDX_W  = 8;

    typedef enum logic [BS_TYPE_W-1:0] {
        IN_NEIGHBOUR = 2'd0,
        IN_IO        = 2'd1,
        IN_FEEDBACK  = 2'd2,
        IN_CONST     = 2'd3
    } in_type_e;

    typedef enum logic [2:0] {
        ST_UNCONFIGURED = 3'd0,
        ST_READ_TYPE    = 3'd1,
        ST_READ_INDEX   = 3'd2,
        ST_READ_TT      = 3'd3,
        ST_READ_MODE    = 3'd4,
        ST_IDLE         = 3'd5,
        ST_RUN          = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/clb_if.sv
`default_nettype none
// ============================================================================
// Module      : clb_if
// Description : Configuration and run-time signal bundle of the CLB cluster.
// Revision    : 1.0 - initial release
// ============================================================================
interface clb_if #(
    parameter int NUM_LUTS              = 2,
    parameter int NUM_NEIGHBOUR_SIGNALS = 8,
    parameter int NUM_IO_SIGNALS        = 4
);
    logic                             cfg_start;
    logic                             cfg_valid;
    logic                             cfg_data;
    logic                             run;
    logic [NUM_NEIGHBOUR_SIGNALS-1:0] run_in_neighbours;
    logic [NUM_IO_SIGNALS-1:0]        run_in_io;
    logic [NUM_LUTS-1:0]              run_out;
    logic                             cfg_done;
    logic                             cfg_err;

    modport master (
        output cfg_start, cfg_valid, cfg_data, run, run_in_neighbours, run_in_io,
        input  run_out, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, run, run_in_neighbours, run_in_io,
        output run_out, cfg_done, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clb_lut_slice.sv
`default_nettype none
// ============================================================================
// Module      : clb_lut_slice
// Description : One LUT: truth table, input selects, input mux, mode and flop.
// Revision    : 1.0 - initial release
// ============================================================================
module clb_lut_slice
    import clb_pkg::*;
#(
    parameter int LUT_WIDTH             = 4,
    parameter int NUM_LUTS              = 2,
    parameter int NUM_NEIGHBOUR_SIGNALS = 8,
    parameter int NUM_IO_SIGNALS        = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_clr_q,
    input  logic                             i_run_en,
    input  logic                             i_wr_in,
    input  logic [$clog2(LUT_WIDTH)-1:0]     i_wr_sel,
    input  in_type_e                         i_wr_type,
    input  logic [BS_IDX_W-1:0]              i_wr_idx,
    input  logic                             i_wr_tt,
    input  logic [LUT_WIDTH-1:0]             i_wr_tt_pos,
    input  logic                             i_wr_mode,
    input  logic                             i_wr_bit,
    input  logic [NUM_NEIGHBOUR_SIGNALS-1:0] i_neighbours,
    input  logic [NUM_IO_SIGNALS-1:0]        i_io,
    input  logic [NUM_LUTS-1:0]              i_fb,
    output logic                             o_q,
    output logic                             o_out
);
    localparam int c_TT_BITS = 1 << LUT_WIDTH;

    in_type_e                         r_type [LUT_WIDTH];
    logic [BS_IDX_W-1:0]              r_idx  [LUT_WIDTH];
    logic [c_TT_BITS-1:0]             r_tt;
    logic                             r_mode;
    logic                             r_q;

    logic [LUT_WIDTH-1:0]             w_in;
    logic [NUM_NEIGHBOUR_SIGNALS-1:0] w_nb_sh;
    logic [NUM_IO_SIGNALS-1:0]        w_io_sh;
    logic [NUM_LUTS-1:0]              w_fb_sh;
    logic                             w_lut;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LUT_WIDTH; k++) begin
                r_type[k] <= IN_NEIGHBOUR;
                r_idx[k]  <= '0;
            end
            r_tt   <= '0;
            r_mode <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            if (i_wr_in) begin
                r_type[i_wr_sel] <= i_wr_type;
                r_idx[i_wr_sel]  <= i_wr_idx;
            end
            if (i_wr_tt) begin
                r_tt[i_wr_tt_pos] <= i_wr_bit;
            end
            if (i_wr_mode) begin
                r_mode <= i_wr_bit;
            end
            if (i_clr_q) begin
                r_q <= 1'b0;
            end else if (i_run_en) begin
                r_q <= w_lut;
            end
        end
    end

    // Feedback taps read flop outputs only, so no combinational loop can form.
    always_comb begin
        w_in    = '0;
        w_nb_sh = '0;
        w_io_sh = '0;
        w_fb_sh = '0;
        for (int k = 0; k < LUT_WIDTH; k++) begin
            w_nb_sh = i_neighbours >> r_idx[k];
            w_io_sh = i_io >> r_idx[k];
            w_fb_sh = i_fb >> r_idx[k];
            case (r_type[k])
                IN_NEIGHBOUR: w_in[k] = w_nb_sh[0];
                IN_IO:        w_in[k] = w_io_sh[0];
                IN_FEEDBACK:  w_in[k] = w_fb_sh[0];
                default:      w_in[k] = r_idx[k][0];
            endcase
        end
    end

    assign w_lut = r_tt[w_in];
    assign o_q   = r_q;
    assign o_out = r_mode ? r_q : w_lut;

endmodule
`default_nettype wire

// File: rtl/clb_cluster.sv
`default_nettype none
// ============================================================================
// Module      : clb_cluster
// Description : Serially configured cluster of LUTs with optional output flops.
// Revision    : 1.0 - initial release
// ============================================================================
module clb_cluster
    import clb_pkg::*;
#(
    parameter int NUM_LUTS              = 2,
    parameter int LUT_WIDTH             = 4,
    parameter int NUM_NEIGHBOUR_SIGNALS = 8,
    parameter int NUM_IO_SIGNALS        = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    clb_if.slave  bus
);
    localparam int         c_TT_BITS = 1 << LUT_WIDTH;
    localparam int         c_IN_W    = $clog2(LUT_WIDTH);
    localparam int         c_LUT_W   = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam logic [6:0] c_TT_LAST = 7'(c_TT_BITS - 1);

    state_e                r_state;
    logic [6:0]            r_bit_cnt;
    logic [c_IN_W-1:0]     r_in_idx;
    logic [c_LUT_W-1:0]    r_lut_idx;
    logic [BS_IDX_W-2:0]   r_sh;
    in_type_e              r_type;
    logic                  r_cfg_err;

    logic                  w_start;
    logic                  w_cfg_done;
    logic                  w_run_en;
    logic                  w_idx_bad;
    logic                  w_wr_in;
    logic                  w_wr_tt;
    logic                  w_wr_mode;
    logic [BS_IDX_W-1:0]   w_idx_full;
    logic [BS_IDX_W-1:0]   w_idx_wr;
    logic [NUM_LUTS-1:0]   w_q;
    logic [NUM_LUTS-1:0]   w_out;

    assign w_start    = bus.cfg_start && (r_state == ST_UNCONFIGURED || r_state == ST_IDLE);
    assign w_cfg_done = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_run_en   = (r_state == ST_RUN) && bus.run;
    assign w_idx_full = {r_sh, bus.cfg_data};
    assign w_wr_in    = (r_state == ST_READ_INDEX) && bus.cfg_valid
                        && (r_bit_cnt == 7'(BS_IDX_W - 1));
    assign w_wr_tt    = (r_state == ST_READ_TT) && bus.cfg_valid;
    assign w_wr_mode  = (r_state == ST_READ_MODE) && bus.cfg_valid;
    assign w_idx_wr   = w_idx_bad ? '0 : w_idx_full;

    always_comb begin
        w_idx_bad = 1'b0;
        case (r_type)
            IN_NEIGHBOUR: w_idx_bad = {1'b0, w_idx_full} >= 9'(NUM_NEIGHBOUR_SIGNALS);
            IN_IO:        w_idx_bad = {1'b0, w_idx_full} >= 9'(NUM_IO_SIGNALS);
            IN_FEEDBACK:  w_idx_bad = {1'b0, w_idx_full} >= 9'(NUM_LUTS);
            default:      w_idx_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_UNCONFIGURED;
            r_bit_cnt <= '0;
            r_in_idx  <= '0;
            r_lut_idx <= '0;
            r_sh      <= '0;
            r_type    <= IN_NEIGHBOUR;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                ST_UNCONFIGURED, ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_READ_TYPE;
                        r_bit_cnt <= '0;
                        r_in_idx  <= '0;
                        r_lut_idx <= '0;
                        r_cfg_err <= 1'b0;
                    end else if (r_state == ST_IDLE && bus.run) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!bus.run) r_state <= ST_IDLE;
                end
                ST_READ_TYPE: begin
                    if (bus.cfg_valid) begin
                        r_sh <= {r_sh[BS_IDX_W-3:0], bus.cfg_data};
                        if (r_bit_cnt == 7'(BS_TYPE_W - 1)) begin
                            r_type    <= in_type_e'({r_sh[BS_TYPE_W-2:0], bus.cfg_data});
                            r_bit_cnt <= '0;
                            r_state   <= ST_READ_INDEX;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 7'd1;
                        end
                    end
                end
                ST_READ_INDEX: begin
                    if (bus.cfg_valid) begin
                        r_sh <= {r_sh[BS_IDX_W-3:0], bus.cfg_data};
                        if (r_bit_cnt == 7'(BS_IDX_W - 1)) begin
                            r_bit_cnt <= '0;
                            if (w_idx_bad) r_cfg_err <= 1'b1;
                            if (r_in_idx == c_IN_W'(LUT_WIDTH - 1)) begin
                                r_in_idx <= '0;
                                r_state  <= ST_READ_TT;
                            end else begin
                                r_in_idx <= r_in_idx + 1'b1;
                                r_state  <= ST_READ_TYPE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 7'd1;
                        end
                    end
                end
                ST_READ_TT: begin
                    if (bus.cfg_valid) begin
                        if (r_bit_cnt == c_TT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_READ_MODE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 7'd1;
                        end
                    end
                end
                ST_READ_MODE: begin
                    if (bus.cfg_valid) begin
                        if (r_lut_idx == c_LUT_W'(NUM_LUTS - 1)) begin
                            r_lut_idx <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_lut_idx <= r_lut_idx + 1'b1;
                            r_state   <= ST_READ_TYPE;
                        end
                    end
                end
                default: r_state <= ST_UNCONFIGURED;
            endcase
        end
    end

    // Truth-table bits arrive highest entry first, so the position is the inverted count.
    generate
        for (genvar gi = 0; gi < NUM_LUTS; gi++) begin : g_lut
            logic w_sel;
            assign w_sel = (r_lut_idx == c_LUT_W'(gi));

            clb_lut_slice #(
                .LUT_WIDTH             (LUT_WIDTH),
                .NUM_LUTS              (NUM_LUTS),
                .NUM_NEIGHBOUR_SIGNALS (NUM_NEIGHBOUR_SIGNALS),
                .NUM_IO_SIGNALS        (NUM_IO_SIGNALS)
            ) u_slice (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_clr_q      (w_start),
                .i_run_en     (w_run_en),
                .i_wr_in      (w_wr_in && w_sel),
                .i_wr_sel     (r_in_idx),
                .i_wr_type    (r_type),
                .i_wr_idx     (w_idx_wr),
                .i_wr_tt      (w_wr_tt && w_sel),
                .i_wr_tt_pos  (~r_bit_cnt[LUT_WIDTH-1:0]),
                .i_wr_mode    (w_wr_mode && w_sel),
                .i_wr_bit     (bus.cfg_data),
                .i_neighbours (bus.run_in_neighbours),
                .i_io         (bus.run_in_io),
                .i_fb         (w_q),
                .o_q          (w_q[gi]),
                .o_out        (w_out[gi])
            );
        end
    endgenerate

    assign bus.run_out  = w_cfg_done ? w_out : '0;
    assign bus.cfg_done = w_cfg_done;
    assign bus.cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_clb_cluster.sv
`default_nettype none
// ============================================================================
// Module      : tb_clb_cluster
// Description : Randomised scoreboard bench for clb_cluster with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clb_cluster;
    localparam int NL      = 2;
    localparam int LW      = 4;
    localparam int NN      = 8;
    localparam int NIO     = 4;
    localparam int TT      = 1 << LW;
    localparam int PER_LUT = LW * 10 + TT + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clb_if #(.NUM_LUTS(NL), .NUM_NEIGHBOUR_SIGNALS(NN), .NUM_IO_SIGNALS(NIO)) bus ();

    clb_cluster #(
        .NUM_LUTS(NL), .LUT_WIDTH(LW), .NUM_NEIGHBOUR_SIGNALS(NN), .NUM_IO_SIGNALS(NIO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NL-1:0] out;
        logic          done;
        logic          err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: abstract configured/loading/running flags plus config tables
    bit          m_cfgd, m_load, m_run, m_err;
    int          m_cnt;
    int          m_type[NL][LW];
    int          m_idx [NL][LW];
    bit [TT-1:0] m_tt  [NL];
    bit          m_mode[NL];
    bit          m_q   [NL];

    int          c_type[NL][LW];
    int          c_idx [NL][LW];
    bit [TT-1:0] c_tt  [NL];
    bit          c_mode[NL];

    int          t_idx [NL][LW];
    bit          bits[$];
    int          bad_at[$];

    function automatic int limit(int ty);
        case (ty)
            0:       return NN;
            1:       return NIO;
            2:       return NL;
            default: return 256;
        endcase
    endfunction

    task automatic build();
        bits.delete();
        bad_at.delete();
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < LW; k++) begin
                bit bad;
                bad = (c_type[l][k] != 3) && (c_idx[l][k] >= limit(c_type[l][k]));
                t_idx[l][k] = bad ? 0 : c_idx[l][k];
                if (bad) bad_at.push_back(l * PER_LUT + k * 10 + 10);
                for (int b = 1; b >= 0; b--) bits.push_back(bit'((c_type[l][k] >> b) & 1));
                for (int b = 7; b >= 0; b--) bits.push_back(bit'((c_idx[l][k] >> b) & 1));
            end
            for (int e = TT - 1; e >= 0; e--) bits.push_back(c_tt[l][e]);
            bits.push_back(c_mode[l]);
        end
    endtask

    function automatic bit lut_val(int l);
        int addr;
        bit v;
        addr = 0;
        for (int k = 0; k < LW; k++) begin
            case (m_type[l][k])
                0:       v = bus.run_in_neighbours[m_idx[l][k]];
                1:       v = bus.run_in_io[m_idx[l][k]];
                2:       v = m_q[m_idx[l][k]];
                default: v = bit'(m_idx[l][k] & 1);
            endcase
            addr += int'(v) << k;
        end
        return m_tt[l][addr];
    endfunction

    task automatic model_edge();
        bit nq[NL];
        if (!rst_n) begin
            m_cfgd = 0; m_load = 0; m_run = 0; m_err = 0; m_cnt = 0;
            for (int l = 0; l < NL; l++) begin
                m_q[l] = 0; m_tt[l] = '0; m_mode[l] = 0;
                for (int k = 0; k < LW; k++) begin m_type[l][k] = 0; m_idx[l][k] = 0; end
            end
        end else if (m_load) begin
            if (bus.cfg_valid) begin
                m_cnt++;
                foreach (bad_at[i]) if (bad_at[i] == m_cnt) m_err = 1;
                if (m_cnt == NL * PER_LUT) begin
                    m_load = 0;
                    m_cfgd = 1;
                    for (int l = 0; l < NL; l++) begin
                        m_tt[l] = c_tt[l]; m_mode[l] = c_mode[l];
                        for (int k = 0; k < LW; k++) begin
                            m_type[l][k] = c_type[l][k]; m_idx[l][k] = t_idx[l][k];
                        end
                    end
                end
            end
        end else if (bus.cfg_start && !m_run) begin
            m_load = 1; m_cnt = 0; m_cfgd = 0; m_err = 0;
            for (int l = 0; l < NL; l++) m_q[l] = 0;
        end else if (m_cfgd && m_run) begin
            if (bus.run) begin
                for (int l = 0; l < NL; l++) nq[l] = lut_val(l);
                for (int l = 0; l < NL; l++) m_q[l] = nq[l];
            end else begin
                m_run = 0;
            end
        end else if (m_cfgd && bus.run) begin
            m_run = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(string nm, bit ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got run_out=%b cfg_done=%b cfg_err=%b",
                     nm, bus.run_out, bus.cfg_done, bus.cfg_err);
        end
    endtask

    task automatic push_exp(string nm);
        exp_t e;
        e.done = m_cfgd;
        e.err  = m_err;
        e.out  = '0;
        if (m_cfgd) for (int l = 0; l < NL; l++) e.out[l] = m_mode[l] ? m_q[l] : lut_val(l);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wait_done(int lim, string nm);
        int n;
        n = 0;
        while (bus.cfg_done !== 1'b1 && n < lim) begin
            push_exp({nm, "_wait"}); tick();
            n++;
        end
        check({nm, "_wait_expired"}, bus.cfg_done === 1'b1);
    endtask

    exp_t  mon_e;
    string mon_nm;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            n_tests++;
            if (bus.run_out !== mon_e.out || bus.cfg_done !== mon_e.done || bus.cfg_err !== mon_e.err) begin
                n_fail++;
                $display("FAIL %s: got run_out=%b cfg_done=%b cfg_err=%b, expected run_out=%b cfg_done=%b cfg_err=%b",
                         mon_nm, bus.run_out, bus.cfg_done, bus.cfg_err, mon_e.out, mon_e.done, mon_e.err);
            end
        end
    end

    task automatic rand_inputs();
        bus.run_in_neighbours = NN'($urandom);
        bus.run_in_io         = NIO'($urandom);
    endtask

    // gap: 0 = always valid, 1 = valid every other cycle, 2 = random gaps
    task automatic load(int gap, int abort_at, string nm);
        int i, cyc;
        bit v;
        bus.run = 0; bus.cfg_valid = 0; bus.cfg_start = 0;
        push_exp({nm, "_pre"}); tick();
        bus.cfg_start = 1; bus.run = 1'($urandom);
        push_exp({nm, "_start"}); tick();
        bus.cfg_start = 0; bus.run = 0;
        i = 0; cyc = 0;
        while (i < bits.size()) begin
            if (i == abort_at) begin
                rst_n = 0; bus.cfg_valid = 0;
                push_exp({nm, "_abort"}); tick();
                rst_n = 1;
                return;
            end
            v = (gap == 0) ? 1'b1 : (gap == 1) ? bit'(cyc % 2) : ($urandom_range(0, 2) != 0);
            bus.cfg_valid = v;
            bus.cfg_data  = v ? bits[i] : 1'($urandom);
            bus.cfg_start = ($urandom_range(0, 15) == 0);
            bus.run       = 1'($urandom);
            rand_inputs();
            push_exp({nm, "_bits"}); tick();
            if (v) i++;
            cyc++;
        end
        bus.cfg_valid = 0; bus.cfg_start = 0; bus.run = 0;
        push_exp({nm, "_done"}); tick();
    endtask

    task automatic run_phase(int n, string nm);
        for (int c = 0; c < n; c++) begin
            bus.run = ($urandom_range(0, 3) != 0);
            bus.cfg_valid = 1'($urandom);
            bus.cfg_data  = 1'($urandom);
            bus.cfg_start = 0;
            rand_inputs();
            push_exp(nm); tick();
        end
    endtask

    task automatic cfg_a();
        for (int k = 0; k < LW; k++) begin
            c_type[0][k] = 0; c_idx[0][k] = k;
            c_type[1][k] = 1; c_idx[1][k] = k;
        end
        c_tt[0] = 16'h8000; c_mode[0] = 0;
        c_tt[1] = 16'h6996; c_mode[1] = 1;
    endtask

    task automatic cfg_rand(bit allow_bad);
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < LW; k++) begin
                int lim;
                c_type[l][k] = int'($urandom_range(0, 3));
                lim = limit(c_type[l][k]);
                if (c_type[l][k] == 3)                          c_idx[l][k] = int'($urandom_range(0, 255));
                else if (allow_bad && $urandom_range(0, 5) == 0) c_idx[l][k] = int'($urandom_range(lim, 255));
                else                                             c_idx[l][k] = int'($urandom_range(0, lim - 1));
            end
            c_tt[l]   = TT'($urandom);
            c_mode[l] = 1'($urandom);
        end
    endtask

    task automatic directed_a(string nm);
        bus.run = 0; bus.cfg_valid = 0;
        bus.run_in_neighbours = 8'h0F; bus.run_in_io = 4'h0;
        push_exp({nm, "_and"}); tick();
        bus.run_in_io = 4'h7; bus.run = 1;
        push_exp({nm, "_io7"}); tick();
        push_exp({nm, "_io7_run"}); tick();
        push_exp({nm, "_io7_q"}); tick();
        bus.run_in_neighbours = 8'h0E;
        push_exp({nm, "_nand"}); tick();
    endtask

    initial begin
        rst_n = 0;
        bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = 0; bus.run = 0;
        bus.run_in_neighbours = '0; bus.run_in_io = '0;
        repeat (2) tick();
        check("reset_state", bus.run_out === '0 && bus.cfg_done === 1'b0 && bus.cfg_err === 1'b0);
        rst_n = 1;
        push_exp("reset"); tick();
        run_phase(12, "unconfigured");

        cfg_a(); build(); load(0, -1, "load_a");
        wait_done(4, "load_a");
        directed_a("a");
        run_phase(30, "run_a");

        cfg_a(); build(); load(1, -1, "gap_a");
        wait_done(4, "gap_a");
        directed_a("gap");
        run_phase(20, "run_gap");

        cfg_rand(0);
        c_type[0][0] = 2; c_idx[0][0] = 0; c_tt[0] = 16'h5555; c_mode[0] = 1;
        for (int k = 1; k < LW; k++) begin c_type[0][k] = 3; c_idx[0][k] = 0; end
        build(); load(2, -1, "toggle");
        bus.run = 1;
        for (int c = 0; c < 6; c++) begin rand_inputs(); push_exp("toggle_run"); tick(); end
        bus.run = 0;
        for (int c = 0; c < 3; c++) begin rand_inputs(); push_exp("toggle_hold"); tick(); end
        run_phase(20, "toggle_rand");

        cfg_a(); c_idx[0][0] = 9; build(); load(0, -1, "badidx");
        bus.run_in_neighbours = 8'h0F;
        push_exp("badidx_nb0_set"); tick();
        bus.run_in_neighbours = 8'h0E;
        push_exp("badidx_nb0_clr"); tick();
        run_phase(15, "badidx_rand");

        cfg_rand(0); build(); load(2, -1, "clean");
        run_phase(15, "clean_rand");

        cfg_a(); build(); load(0, 30, "abort");
        run_phase(8, "after_abort");
        cfg_a(); build(); load(0, -1, "reload_a");
        wait_done(4, "reload_a");
        directed_a("reload");

        for (int r = 0; r < 6; r++) begin
            cfg_rand(1); build(); load(2, -1, "rand_load");
            run_phase(25, "rand_run");
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
